// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - register-file access sequencer (reads, full writes, half-word RMW)
//
// Sequences pipeline read/writeback requests onto the pins of a register file
// whose outputs are registered (one-cycle read latency). A half-word write is
// a read-modify-write because the RF only writes full words.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   wr_req_*            writeback request: valid/ready, addr, data, mode
//                       (00 full, 01 low half, 10 high half, 11 as full)
//   rd_req_*            operand read request: valid/ready, addr_a, addr_b
//   rd_rsp_valid        one-cycle pulse, rd_data_a/b valid while high
//   rd_data_a/b         operand data, pass-through of rf_reg_out1/2
//   rf_reg_port1/2      RF read addresses (registered)
//   rf_write_reg        RF write / port-3 address (registered)
//   rf_data_in          RF write data (combinational)
//   rf_we               RF write enable (registered)
//   rf_hl               RF half select, tied low
//   rf_reg_out1/2/3     RF registered outputs
module rf_access_ctrl #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_mode,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          rd_rsp_valid,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic [AW-1:0] rf_reg_port1,
  output logic [AW-1:0] rf_reg_port2,
  output logic [AW-1:0] rf_write_reg,
  output logic [DW-1:0] rf_data_in,
  output logic          rf_we,
  output logic          rf_hl,
  input  logic [DW-1:0] rf_reg_out1,
  input  logic [DW-1:0] rf_reg_out2,
  input  logic [DW-1:0] rf_reg_out3
);

  localparam int HW = DW / 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FW     = 3'd1,
    S_RD_ISS = 3'd2,
    S_RD_CAP = 3'd3,
    S_HW_ISS = 3'd4,
    S_HW_MRG = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] port1_q, port1_d;
  logic [AW-1:0] port2_q, port2_d;
  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    mode_q, mode_d;
  logic          we_q, we_d;

  logic idle;
  logic wr_accept;
  logic rd_accept;
  logic wr_is_half;

  assign idle       = (state_q == S_IDLE);
  assign wr_accept  = idle && wr_req_valid;
  // Writes win over reads so a read accepted next sees the new value.
  assign rd_accept  = idle && !wr_req_valid && rd_req_valid;
  assign wr_is_half = (wr_mode == 2'b01) || (wr_mode == 2'b10);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      port1_q <= '0;
      port2_q <= '0;
      wreg_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
      wreg_q  <= wreg_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          state_d = wr_is_half ? S_HW_ISS : S_FW;
        end else if (rd_accept) begin
          state_d = S_RD_ISS;
        end
      end
      S_FW:     state_d = S_IDLE;
      S_RD_ISS: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_IDLE;
      S_HW_ISS: state_d = S_HW_MRG;
      S_HW_MRG: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath-update logic
  always_comb begin
    port1_d      = port1_q;
    port2_d      = port2_q;
    wreg_d       = wreg_q;
    data_d       = data_q;
    mode_d       = mode_q;
    we_d         = 1'b0;
    rd_rsp_valid = 1'b0;
    rf_data_in   = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          wreg_d = wr_addr;
          data_d = wr_data;
          mode_d = wr_mode;
          // Half writes first spend a cycle reading the old word via out3.
          we_d   = !wr_is_half;
        end else if (rd_accept) begin
          port1_d = rd_addr_a;
          port2_d = rd_addr_b;
        end
      end
      S_RD_CAP: rd_rsp_valid = 1'b1;
      S_HW_ISS: we_d = 1'b1;
      S_HW_MRG: begin
        // out3 holds the old word captured at the end of HW_ISS.
        if (mode_q == 2'b01) begin
          rf_data_in = {rf_reg_out3[DW-1:HW], data_q[HW-1:0]};
        end else begin
          rf_data_in = {data_q[HW-1:0], rf_reg_out3[HW-1:0]};
        end
      end
      default: ;
    endcase
  end

  assign wr_req_ready = idle;
  assign rd_req_ready = idle && !wr_req_valid;
  assign rd_data_a    = rf_reg_out1;
  assign rd_data_b    = rf_reg_out2;
  assign rf_reg_port1 = port1_q;
  assign rf_reg_port2 = port2_q;
  assign rf_write_reg = wreg_q;
  assign rf_we        = we_q;
  assign rf_hl        = 1'b0;

endmodule
